eth_tcap_encap_var: RTL and testbench
=====================================

ETH_TCAP_ENCAP_VAR -- requirements
Module: eth_tcap_encap_var

Interface
REQ-001 Parameter eth_dst, 48'h90_E2_BA_5D_8D_C9, destination MAC.
REQ-002 Parameter eth_src, 48'h00_11_22_33_44_55, source MAC.
REQ-003 Parameter ip_saddr / ip_daddr, 192.168.11.1 / 192.168.11.3, IPv4 addresses.
REQ-004 Parameter udp_sport / udp_dport, 16'h3776 / 16'h3776, UDP ports.
REQ-005 Parameter tcap_dir, 1'b0, value of tcap dir field.
REQ-006 Parameter max_payload, 16'd1466, largest accepted TLP payload in bytes.
REQ-007 clk156  in  1  sole clock; sys_rst  in  1  reset, synchronous, active-high.
REQ-008 rd_en  out  1; dout  in  74  FWFT word {tkeep[7:0], tdata[63:0], tlast, tuser}; empty  in  1.
REQ-009 len_rd_en  out  1; len_dout  in  16  payload byte count of next packet; len_empty  in  1.
REQ-010 m_axis_tready in 1; m_axis_tvalid out 1; m_axis_tdata out 64; m_axis_tkeep out 8; m_axis_tlast out 1; m_axis_tuser out 1.
REQ-011 frames_sent  out  32; frames_dropped  out  32  statistics counters.

Function
REQ-012 States SHALL be IDLE, PREP, HDR, DROP, DATA.
REQ-013 IDLE->PREP when !len_empty && !empty; len_rd_en pulses one cycle, L = len_dout captured.
REQ-014 PREP (1 cycle): if L==0 or L>max_payload -> DROP, else compute headers -> HDR; no output.
REQ-015 Header = 48 B: Ethernet 14, IPv4 20, UDP 8, tcap 6; 6 beats, all tkeep=8'hFF, tlast=0, tuser=0.
REQ-016 ip tot_len = 34+L; udp len = 14+L; udp check = 0; ver 4, ihl 5, ttl 64, proto 17, id/frag/tos 0.
REQ-017 IP checksum computed in PREP from captured L: 16-bit one's-complement sum, end-around carry folded twice, inverted.
REQ-018 tcap: ver 3'b001, dir = tcap_dir, rsrv 0, ts = 40-bit sequence; sequence increments in PREP only for accepted packets; first frame ts=1; wraps 2^40-1 -> 0.
REQ-019 Byte order on wire: first byte in m_axis_tdata[7:0], enabled by m_axis_tkeep[0]; dout tkeep/tdata converted (byte-reversed) to this order.
REQ-020 HDR: beat counter advances only on tvalid&&tready; after beat 5 accepted -> DATA.
REQ-021 DATA: m_axis_tvalid = !empty; tkeep/tdata/tlast/tuser from dout; rd_en = m_axis_tready && !empty.
REQ-022 Output SHALL hold stable while tvalid && !tready (AXI-Stream); rd_en never asserted without a transfer.
REQ-023 DATA -> IDLE on transfer with tlast=1; frames_sent increments that cycle.
REQ-024 DROP: rd_en = !empty, m_axis_tvalid=0; on consumed word with tlast=1 -> IDLE, frames_dropped +1.
REQ-025 Payload length from L and tlast position are not cross-checked; tlast alone ends a frame.
REQ-026 Counters saturate at 32'hFFFF_FFFF.
REQ-027 Back-to-back: next packet accepted from IDLE cycle after tlast; min gap 2 cycles (IDLE, PREP).

Reset
REQ-028 sys_rst SHALL force IDLE, sequence=0, counters=0, beat counter=0; all outputs 0 that cycle and next.
REQ-029 Reset mid-frame abandons frame without tlast; no FIFO words consumed during reset.

Verification
REQ-030 L=32, 4 payload words, tready=1 -> 10 beats; IP check 16'hE356, tot_len 66, udp len 46, ts=1, frames_sent=1.
REQ-031 Same packet, tready toggled every cycle -> identical beat stream, data stable while stalled, no word lost.
REQ-032 L=0 then L=1467 each with 3 words -> no output, 6 words consumed, frames_dropped=2, next valid frame ts=1.
REQ-033 Last word tkeep 8'h0F (dout order) -> m_axis_tkeep 8'hF0-reversed mapping verified, tlast=1.
REQ-034 Preload sequence to 2^40-1 via forced sends -> next frame ts=0.
REQ-035 sys_rst asserted on header beat 3 -> tvalid=0 next cycle, counters 0, following frame starts with beat 0, ts=1.

Source files
------------

// File: rtl/eth_tcap_encap_var.sv
// Wraps TLP payload words from a FWFT FIFO into Ethernet/IPv4/UDP/tcap frames.
// Packets that are empty or oversized are drained from the FIFO and counted.
module eth_tcap_encap_var #(
  parameter logic [47:0] eth_dst     = 48'h90_E2_BA_5D_8D_C9,
  parameter logic [47:0] eth_src     = 48'h00_11_22_33_44_55,
  parameter logic [31:0] ip_saddr    = 32'hC0_A8_0B_01,
  parameter logic [31:0] ip_daddr    = 32'hC0_A8_0B_03,
  parameter logic [15:0] udp_sport   = 16'h3776,
  parameter logic [15:0] udp_dport   = 16'h3776,
  parameter logic        tcap_dir    = 1'b0,
  parameter logic [15:0] max_payload = 16'd1466
) (
  input  logic        clk156,
  input  logic        sys_rst,
  output logic        rd_en,
  input  logic [73:0] dout,
  input  logic        empty,
  output logic        len_rd_en,
  input  logic [15:0] len_dout,
  input  logic        len_empty,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] frames_sent,
  output logic [31:0] frames_dropped
);

  localparam int unsigned HDR_BYTES = 48;
  localparam int unsigned HDR_BITS  = HDR_BYTES * 8;

  typedef enum logic [2:0] {IDLE, PREP, HDR, DROP, DATA} state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [39:0]   seq_q, seq_d;
  logic [15:0]   csum_q, csum_d;
  logic [2:0]    beat_q, beat_d;
  logic [31:0]   sent_q, sent_d;
  logic [31:0]   dropped_q, dropped_d;

  logic [15:0]         tot_len, udp_len;
  logic [19:0]         sum_c;
  logic [16:0]         fold1;
  logic [15:0]         fold2;
  logic [HDR_BITS-1:0] hdr_be, hdr_le;
  logic [63:0]         fifo_data;
  logic [7:0]          fifo_keep;
  logic                fifo_last;

  // Header fields, IPv4 checksum and FIFO byte-order conversion
  always_comb begin
    tot_len = 16'd34 + len_q;
    udp_len = 16'd14 + len_q;
    sum_c = 20'(16'h4500) + 20'(tot_len) + 20'(16'h4011) +
            20'(ip_saddr[31:16]) + 20'(ip_saddr[15:0]) +
            20'(ip_daddr[31:16]) + 20'(ip_daddr[15:0]);
    fold1 = 17'(sum_c[15:0]) + 17'(sum_c[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    hdr_be = {eth_dst, eth_src, 16'h0800,
              16'h4500, tot_len, 32'h0, 16'h4011, csum_q, ip_saddr, ip_daddr,
              udp_sport, udp_dport, udp_len, 16'h0,
              3'b001, tcap_dir, 4'h0, seq_q};
    hdr_le = '0;
    for (int i = 0; i < int'(HDR_BYTES); i++) begin
      hdr_le[8*i +: 8] = hdr_be[HDR_BITS-1-8*i -: 8];
    end
    fifo_data = '0;
    fifo_keep = '0;
    for (int j = 0; j < 8; j++) begin
      fifo_data[8*j +: 8] = dout[2+8*(7-j) +: 8];
      fifo_keep[j]        = dout[66+(7-j)];
    end
    fifo_last = dout[1];
  end

  // Next state, counters and stream outputs
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    seq_d          = seq_q;
    csum_d         = csum_q;
    beat_d         = beat_q;
    sent_d         = sent_q;
    dropped_d      = dropped_q;
    rd_en          = 1'b0;
    len_rd_en      = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!len_empty && !empty) begin
          len_rd_en = 1'b1;
          len_d     = len_dout;
          state_d   = PREP;
        end
      end
      PREP: begin
        if (len_q == 16'd0 || len_q > max_payload) begin
          state_d = DROP;
        end else begin
          seq_d   = seq_q + 40'd1;
          csum_d  = ~fold2;
          beat_d  = 3'd0;
          state_d = HDR;
        end
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_le[{beat_q, 6'd0} +: 64];
        m_axis_tkeep  = 8'hFF;
        if (m_axis_tready) begin
          if (beat_q == 3'd5) begin
            beat_d  = 3'd0;
            state_d = DATA;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      DATA: begin
        m_axis_tvalid = !empty;
        m_axis_tdata  = fifo_data;
        m_axis_tkeep  = fifo_keep;
        m_axis_tlast  = fifo_last;
        m_axis_tuser  = dout[0];
        rd_en         = m_axis_tready && !empty;
        if (m_axis_tready && !empty && fifo_last) begin
          state_d = IDLE;
          if (sent_q != 32'hFFFF_FFFF) sent_d = sent_q + 32'd1;
        end
      end
      DROP: begin
        rd_en = !empty;
        if (!empty && fifo_last) begin
          state_d = IDLE;
          if (dropped_q != 32'hFFFF_FFFF) dropped_d = dropped_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    frames_sent    = sent_q;
    frames_dropped = dropped_q;
    // Outputs read as zero while reset is held, not only after it is taken
    if (sys_rst) begin
      rd_en          = 1'b0;
      len_rd_en      = 1'b0;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tkeep   = '0;
      m_axis_tlast   = 1'b0;
      m_axis_tuser   = 1'b0;
      frames_sent    = '0;
      frames_dropped = '0;
    end
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      seq_q     <= '0;
      csum_q    <= '0;
      beat_q    <= '0;
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      csum_q    <= csum_d;
      beat_q    <= beat_d;
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_eth_tcap_encap_var.sv
// Directed bench for eth_tcap_encap_var: FWFT FIFO models, stream monitor, header vectors.
module tb_eth_tcap_encap_var;

  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rd_en, len_rd_en;
  logic [73:0] dout = '0;
  logic        empty = 1'b1;
  logic [15:0] len_dout = '0;
  logic        len_empty = 1'b1;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tuser;
  logic [31:0] frames_sent, frames_dropped;

  eth_tcap_encap_var dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .rd_en(rd_en), .dout(dout), .empty(empty),
    .len_rd_en(len_rd_en), .len_dout(len_dout), .len_empty(len_empty),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  always #5 clk156 = ~clk156;

  // Expected header beats for L=32 (checksum E356, tot_len 0x42, udp len 0x2E)
  localparam logic [63:0] HDR_EXP [0:4] = '{
    64'h1100_C98D_5DBA_E290,
    64'h0045_0008_5544_3322,
    64'h1140_0000_0000_4200,
    64'hA8C0_010B_A8C0_56E3,
    64'h2E00_7637_7637_030B
  };
  localparam logic [63:0] BEAT5_TS0 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] BEAT5_TS1 = 64'h0100_0000_0020_0000;
  localparam logic [63:0] BEAT5_TS2 = 64'h0200_0000_0020_0000;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [73:0] dq[$];
  logic [15:0] lq[$];
  logic        pop_d, pop_l;
  logic        toggle = 1'b0;

  // FWFT FIFO models: pop what the DUT consumed at this edge, then present the new head
  always @(posedge clk156) begin
    pop_d = rd_en && !empty;
    pop_l = len_rd_en && !len_empty;
    #1;
    if (pop_d && dq.size() > 0) void'(dq.pop_front());
    if (pop_l && lq.size() > 0) void'(lq.pop_front());
    empty     = (dq.size() == 0);
    dout      = empty ? 74'h0 : dq[0];
    len_empty = (lq.size() == 0);
    len_dout  = len_empty ? 16'h0 : lq[0];
  end

  always @(posedge clk156) begin
    #2;
    m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
  end

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t mon[$];
  beat_t cur, held;
  logic  stalled = 1'b0;
  int    stall_err = 0;

  assign cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};

  // Stream monitor: records transfers and flags any change while stalled
  always @(negedge clk156) begin
    if (stalled && (!m_axis_tvalid || cur != held)) stall_err++;
    if (m_axis_tvalid && m_axis_tready) mon.push_back(cur);
    stalled = m_axis_tvalid && !m_axis_tready;
    held    = cur;
  end

  function automatic logic [63:0] pay(input int i);
    return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk156);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] len, input int nw, input logic [7:0] last_keep);
    lq.push_back(len);
    for (int i = 0; i < nw; i++) begin
      dq.push_back({(i == nw - 1) ? last_keep : 8'hFF, pay(i), i == nw - 1, i == 1});
    end
  endtask

  task automatic wait_mon(input int n);
    int cyc = 0;
    while (mon.size() < n && cyc < 400) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    check("beat_count", 64'(mon.size()), 64'(n));
  endtask

  task automatic check_frame(input int nw, input logic [7:0] exp_last_keep, input logic [63:0] beat5);
    wait_mon(6 + nw);
    if (mon.size() == 6 + nw) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("hdr%0d_data", k), mon[k].d, (k < 5) ? HDR_EXP[k] : beat5);
        check($sformatf("hdr%0d_keep", k), 64'(mon[k].k), 64'hFF);
        check($sformatf("hdr%0d_last_user", k), 64'({mon[k].l, mon[k].u}), 64'h0);
      end
      for (int i = 0; i < nw; i++) begin
        check($sformatf("pay%0d_data", i), mon[6+i].d, rev64(pay(i)));
        check($sformatf("pay%0d_keep", i), 64'(mon[6+i].k),
              64'((i == nw - 1) ? exp_last_keep : 8'hFF));
        check($sformatf("pay%0d_last", i), 64'(mon[6+i].l), 64'(i == nw - 1));
        check($sformatf("pay%0d_user", i), 64'(mon[6+i].u), 64'(i == 1));
      end
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    check("rst_rd_en", 64'({rd_en, len_rd_en}), 64'h0);
    check("rst_counters", {frames_sent, frames_dropped}, 64'h0);
    tick();
    tick();
    check("rst_tvalid_hold", 64'(m_axis_tvalid), 64'h0);
    sys_rst = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    do_reset();

    // Basic frame, L=32, tready held high
    mon.delete();
    push_frame(16'd32, 4, 8'hFF);
    check_frame(4, 8'hFF, BEAT5_TS1);
    check("a_sent", 64'(frames_sent), 64'd1);
    check("a_dropped", 64'(frames_dropped), 64'd0);

    // Same packet with tready toggling every cycle
    mon.delete();
    stall_err = 0;
    toggle = 1'b1;
    push_frame(16'd32, 4, 8'hFF);
    check_frame(4, 8'hFF, BEAT5_TS2);
    toggle = 1'b0;
    tick();
    check("b_stall_stable", 64'(stall_err), 64'd0);
    check("b_sent", 64'(frames_sent), 64'd2);
    check("b_fifo_drained", 64'(dq.size()), 64'd0);

    // Empty and oversized packets are drained and counted
    do_reset();
    mon.delete();
    push_frame(16'd0, 3, 8'hFF);
    push_frame(16'd1467, 3, 8'hFF);
    for (int c = 0; c < 100 && frames_dropped < 2; c++) tick();
    repeat (4) tick();
    check("c_dropped", 64'(frames_dropped), 64'd2);
    check("c_words_left", 64'(dq.size()), 64'd0);
    check("c_no_output", 64'(mon.size()), 64'd0);
    check("c_sent", 64'(frames_sent), 64'd0);

    // Partial last word, first accepted frame after drops carries ts=1
    mon.delete();
    push_frame(16'd32, 4, 8'h0F);
    check_frame(4, 8'hF0, BEAT5_TS1);
    check("d_sent", 64'(frames_sent), 64'd1);

    // Sequence wrap from 2^40-1 to 0
    force dut.seq_q = 40'hFF_FFFF_FFFF;
    #1;
    release dut.seq_q;
    tick();
    mon.delete();
    push_frame(16'd32, 4, 8'hFF);
    check_frame(4, 8'hFF, BEAT5_TS0);
    check("e_sent", 64'(frames_sent), 64'd2);

    // Reset while header beat 3 is presented
    mon.delete();
    push_frame(16'd32, 4, 8'hFF);
    for (int c = 0; c < 100 && mon.size() < 4; c++) tick();
    check("f_reached_beat3", 64'(mon.size()), 64'd4);
    do_reset();
    check("f_tvalid_after", 64'(m_axis_tvalid), 64'h0);
    check("f_words_kept", 64'(dq.size()), 64'd4);
    check("f_counters", {frames_sent, frames_dropped}, 64'h0);
    dq.delete();
    repeat (2) tick();
    mon.delete();
    push_frame(16'd32, 4, 8'hFF);
    check_frame(4, 8'hFF, BEAT5_TS1);
    check("f_sent", 64'(frames_sent), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
